// File: rtl/pipeline_stage_sequencer.sv
// Write-enable sequencer for an N-stage RV32 datapath with run-time SEQ/PIPE modes.
// Optional retired/stall counters are enabled by defining PIPELINE_STAGE_SEQUENCER_PERF_EN.
module pipeline_stage_sequencer #(
  parameter int unsigned N_STAGES     = 5,
  parameter int unsigned MEM_STAGE    = 3,
  parameter int unsigned FLUSH_STAGE  = 3,
  parameter int unsigned INIT_CYCLES  = 2,
  parameter bit          MODE_DEFAULT = 1'b0,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                mode_req,
  input  logic                stall_req,
  input  logic                hazard_stall,
  input  logic                flush_req,
  output logic                mode,
  output logic                pc_wren,
  output logic [N_STAGES-2:0] pipe_wren,
  output logic [N_STAGES-1:0] stage_valid,
  output logic                ram_wren,
  output logic                reg_wren,
  output logic                stage_reset_n,
  output logic                draining
`ifdef PIPELINE_STAGE_SEQUENCER_PERF_EN
  ,
  output logic [PERF_W-1:0]   retired_count,
  output logic [PERF_W-1:0]   stall_count
`endif
);

  localparam int unsigned TW = $clog2(N_STAGES);
  localparam int unsigned IW = $clog2(INIT_CYCLES + 1);

  typedef enum logic {M_SEQ = 1'b0, M_PIPE = 1'b1} mode_e;

  if ((N_STAGES < 3) || (MEM_STAGE < 1) || (MEM_STAGE > N_STAGES - 2) ||
      (FLUSH_STAGE < 1) || (FLUSH_STAGE > N_STAGES - 2) ||
      (INIT_CYCLES < 1) || (PERF_W < 1)) begin : g_bad_params
    $error("pipeline_stage_sequencer: illegal parameter combination");
  end

  mode_e               r_mode,      w_mode_nxt;
  logic                r_draining,  w_draining_nxt;
  logic [TW-1:0]       r_token,     w_token_nxt;
  logic [N_STAGES-1:0] r_valid,     w_valid_nxt;
  logic [IW-1:0]       r_init_cnt,  w_init_cnt_nxt;
  logic                r_srst_n,    w_srst_n_nxt;
  logic                w_switch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mode     <= mode_e'(MODE_DEFAULT);
      r_draining <= 1'b0;
      r_token    <= '0;
      r_valid    <= '0;
      r_init_cnt <= '0;
      r_srst_n   <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_draining <= w_draining_nxt;
      r_token    <= w_token_nxt;
      r_valid    <= w_valid_nxt;
      r_init_cnt <= w_init_cnt_nxt;
      r_srst_n   <= w_srst_n_nxt;
    end
  end

  always_comb begin
    w_mode_nxt     = r_mode;
    w_draining_nxt = r_draining;
    w_token_nxt    = r_token;
    w_valid_nxt    = r_valid;
    w_init_cnt_nxt = r_init_cnt;
    w_srst_n_nxt   = r_srst_n;
    w_switch       = 1'b0;
    pc_wren        = 1'b0;
    pipe_wren      = '0;
    ram_wren       = 1'b0;
    reg_wren       = 1'b0;

    if (!r_srst_n) begin
      if (r_init_cnt == IW'(INIT_CYCLES - 1)) begin
        w_srst_n_nxt = 1'b1;
        w_valid_nxt  = N_STAGES'(1);
      end else begin
        w_init_cnt_nxt = r_init_cnt + IW'(1);
      end
    end else begin
      if (!r_draining && (mode_req != r_mode)) begin
        w_draining_nxt = 1'b1;
      end
      // An empty stage_valid while draining marks the switch cycle in both modes;
      // SEQ clears it after the final write-back of a drain.
      w_switch = r_draining && (r_valid == '0) && !stall_req;
      if (w_switch) begin
        w_mode_nxt     = (r_mode == M_SEQ) ? M_PIPE : M_SEQ;
        w_draining_nxt = 1'b0;
        w_token_nxt    = '0;
        w_valid_nxt    = N_STAGES'(1);
      end else if (stall_req) begin
        w_valid_nxt = r_valid;
      end else if (r_mode == M_SEQ) begin
        if (r_token == TW'(N_STAGES - 1)) begin
          pc_wren     = 1'b1;
          reg_wren    = 1'b1;
          w_token_nxt = '0;
          w_valid_nxt = r_draining ? '0 : N_STAGES'(1);
        end else begin
          for (int unsigned k = 0; k < N_STAGES - 1; k++) begin
            pipe_wren[k] = (r_token == TW'(k));
          end
          ram_wren    = (r_token == TW'(MEM_STAGE));
          w_token_nxt = r_token + TW'(1);
          w_valid_nxt = r_valid << 1;
        end
      end else begin
        pc_wren   = 1'b1;
        pipe_wren = '1;
        ram_wren  = r_valid[MEM_STAGE];
        reg_wren  = r_valid[N_STAGES-1];
        if (flush_req) begin
          for (int unsigned i = FLUSH_STAGE + 1; i < N_STAGES; i++) begin
            w_valid_nxt[i] = r_valid[i-1];
          end
          for (int unsigned i = 1; i <= FLUSH_STAGE; i++) begin
            w_valid_nxt[i] = 1'b0;
          end
          w_valid_nxt[0] = ~r_draining;
        end else if (hazard_stall) begin
          pc_wren        = 1'b0;
          pipe_wren[0]   = 1'b0;
          w_valid_nxt[2] = 1'b0;
          for (int unsigned i = 3; i < N_STAGES; i++) begin
            w_valid_nxt[i] = r_valid[i-1];
          end
        end else begin
          w_valid_nxt = {r_valid[N_STAGES-2:0], ~r_draining};
        end
      end
    end
  end

  assign mode          = r_mode;
  assign stage_valid   = r_valid;
  assign stage_reset_n = r_srst_n;
  assign draining      = r_draining;

`ifdef PIPELINE_STAGE_SEQUENCER_PERF_EN
  logic [PERF_W-1:0] r_retired_count;
  logic [PERF_W-1:0] r_stall_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired_count <= '0;
      r_stall_count   <= '0;
    end else begin
      if (reg_wren) begin
        r_retired_count <= r_retired_count + PERF_W'(1);
      end
      if (r_srst_n && (stall_req || hazard_stall)) begin
        r_stall_count <= r_stall_count + PERF_W'(1);
      end
    end
  end

  assign retired_count = r_retired_count;
  assign stall_count   = r_stall_count;
`endif

endmodule
